// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin arbiter for the shared single-port coin/state memory.
// One transaction at a time; operands are latched when the winner is picked in IDLE,
// the address is held through the read latency, and the owner sees a one-cycle ack.
module memory_arbiter #(
    parameter int DATA_W   = 48,
    parameter int ADDR_W   = 5,
    parameter int READ_LAT = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [2:0]        req,
    input  logic [2:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [DATA_W-1:0] wdata2,
    output logic [2:0]        grant,
    output logic [2:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Counter reload: WAIT lasts READ_LAT cycles, the last one with the counter at 0.
    localparam logic [3:0] CNT_INIT = 4'(READ_LAT - 1);

    state_t            state_q;
    state_t            state_d;
    logic [1:0]        idx_q;
    logic [1:0]        last_q;
    logic              we_q;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic              any_req;
    logic [1:0]        win;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [2:0]        owner;

    // Round-robin pick: search starts one past the last served requester and wraps.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] start;
        logic [2:0] cand;
        logic [1:0] pick;
        start = (last == 2'd2) ? 2'd0 : last + 2'd1;
        pick  = 2'd0;
        // Walk candidates farthest-first so the nearest requesting one wins.
        for (int k = 2; k >= 0; k--) begin
            cand = {1'b0, start} + 3'(k);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            if (r[cand[1:0]]) begin
                pick = cand[1:0];
            end
        end
        return pick;
    endfunction

    assign any_req = |req;
    assign win     = rr_pick(req, last_q);

    // Operand mux selecting the winning requester's access type, address and data.
    always_comb begin
        sel_we    = we[0];
        sel_addr  = addr0;
        sel_wdata = wdata0;
        case (win)
            2'd1: begin
                sel_we    = we[1];
                sel_addr  = addr1;
                sel_wdata = wdata1;
            end
            2'd2: begin
                sel_we    = we[2];
                sel_addr  = addr2;
                sel_wdata = wdata2;
            end
            default: ;
        endcase
    end

    // Next-state logic for the IDLE -> ISSUE -> (WAIT) -> DONE transaction sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ISSUE;
            ISSUE:   state_d = we_q ? DONE : WAIT;
            WAIT:    if (cnt_q == 4'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control registers: state, owner, access type, latency counter, round-robin pointer, read data.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            last_q  <= 2'd2;
            we_q    <= 1'b0;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        idx_q <= win;
                        we_q  <= sel_we;
                    end
                end
                ISSUE: begin
                    if (!we_q) begin
                        cnt_q <= CNT_INIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        rdata_q <= mem_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    last_q <= idx_q;
                end
                default: ;
            endcase
        end
    end

    // Operand latch; its contents only reach the port outside IDLE, so it needs no reset.
    always_ff @(posedge clock) begin
        if (state_q == IDLE && any_req) begin
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
        end
    end

    assign owner     = 3'b001 << idx_q;
    assign busy      = (state_q != IDLE);
    assign grant     = busy ? owner : 3'b000;
    assign ack       = (state_q == DONE) ? owner : 3'b000;
    assign mem_addr  = busy ? addr_q : '0;
    assign mem_wdata = busy ? wdata_q : '0;
    assign mem_we    = (state_q == ISSUE) && we_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a two-cycle-latency memory model.
module tb_memory_arbiter;

    localparam int DATA_W = 48;
    localparam int ADDR_W = 5;

    logic              clock;
    logic              resetn;
    logic [2:0]        req;
    logic [2:0]        we;
    logic [ADDR_W-1:0] addr0, addr1, addr2;
    logic [DATA_W-1:0] wdata0, wdata1, wdata2;
    logic [2:0]        grant;
    logic [2:0]        ack;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_q;

    logic [DATA_W-1:0] mem [0:31];
    logic [DATA_W-1:0] q1, q2;
    logic              load;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;

    int vectors;
    int errors;

    memory_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LAT(2)) dut (
        .clock(clock), .resetn(resetn), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
        .grant(grant), .ack(ack), .rdata(rdata), .busy(busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_q(mem_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: write on mem_we, read data valid two cycles after the address.
    always @(posedge clock) begin
        if (load) mem[load_addr] <= load_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        q1 <= mem[mem_addr];
        q2 <= q1;
    end
    assign mem_q = q2;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int n;
        logic [2:0] eg, ea;
        vectors = 0; errors = 0;
        resetn = 1'b0; req = 3'b000; we = 3'b000;
        addr0 = '0; addr1 = '0; addr2 = '0;
        wdata0 = '0; wdata1 = '0; wdata2 = '0;
        load = 1'b0; load_addr = '0; load_data = '0;

        // Reset state
        tick(); tick();
        check("rst_grant", 64'(grant), 64'(3'b000));
        check("rst_ack", 64'(ack), 64'(3'b000));
        check("rst_busy", 64'(busy), 64'(1'b0));
        check("rst_rdata", 64'(rdata), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        check("rst_mem_we", 64'(mem_we), 64'(1'b0));
        load = 1'b1; load_addr = 5'd5; load_data = 48'h00000000ABCD;
        tick();
        load = 1'b0;
        resetn = 1'b1;

        // Single read by requester 1 from address 5
        req = 3'b010; we = 3'b000; addr1 = 5'd5;
        for (int c = 1; c <= 5; c++) begin
            tick();
            check("rd_grant", 64'(grant), (c <= 4) ? 64'(3'b010) : 64'(0));
            check("rd_ack", 64'(ack), (c == 4) ? 64'(3'b010) : 64'(0));
            check("rd_mem_we", 64'(mem_we), 64'(0));
            if (c <= 3) check("rd_mem_addr", 64'(mem_addr), 64'(5));
            if (c == 4) begin
                check("rd_rdata", 64'(rdata), 64'(48'h00000000ABCD));
                req = 3'b000;
            end
        end
        check("rd_busy_end", 64'(busy), 64'(0));

        // Single write by requester 0, then read it back
        req = 3'b001; we = 3'b001; addr0 = 5'd3; wdata0 = 48'h123456789ABC;
        for (int c = 1; c <= 3; c++) begin
            tick();
            check("wr_mem_we", 64'(mem_we), (c == 1) ? 64'(1) : 64'(0));
            check("wr_ack", 64'(ack), (c == 2) ? 64'(3'b001) : 64'(0));
            if (c == 1) begin
                check("wr_mem_addr", 64'(mem_addr), 64'(3));
                check("wr_mem_wdata", 64'(mem_wdata), 64'(48'h123456789ABC));
            end
            if (c == 2) req = 3'b000;
        end
        req = 3'b001; we = 3'b000;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check("rb_ack", 64'(ack), (c == 4) ? 64'(3'b001) : 64'(0));
            if (c == 4) begin
                check("rb_rdata", 64'(rdata), 64'(48'h123456789ABC));
                req = 3'b000;
            end
        end
        tick();

        // Simultaneous writes after reset: order 0,1,2 with acks in cycles 2,5,8
        resetn = 1'b0; tick(); resetn = 1'b1;
        addr0 = 5'd10; addr1 = 5'd11; addr2 = 5'd12;
        wdata0 = 48'hA0A0A0A0A0A0; wdata1 = 48'hB1B1B1B1B1B1; wdata2 = 48'hC2C2C2C2C2C2;
        req = 3'b111; we = 3'b111;
        for (int c = 1; c <= 9; c++) begin
            tick();
            case (c)
                1: begin eg = 3'b001; ea = 3'b000; end
                2: begin eg = 3'b001; ea = 3'b001; end
                4: begin eg = 3'b010; ea = 3'b000; end
                5: begin eg = 3'b010; ea = 3'b010; end
                7: begin eg = 3'b100; ea = 3'b000; end
                8: begin eg = 3'b100; ea = 3'b100; end
                default: begin eg = 3'b000; ea = 3'b000; end
            endcase
            check("sim_grant", 64'(grant), 64'(eg));
            check("sim_ack", 64'(ack), 64'(ea));
            req = req & ~ack;
        end
        check("sim_mem0", 64'(mem[10]), 64'(48'hA0A0A0A0A0A0));
        check("sim_mem1", 64'(mem[11]), 64'(48'hB1B1B1B1B1B1));
        check("sim_mem2", 64'(mem[12]), 64'(48'hC2C2C2C2C2C2));

        // Fairness: requesters 0 and 2 hold req for 8 transactions
        addr0 = 5'd13; addr2 = 5'd14;
        req = 3'b101; we = 3'b101;
        n = 0;
        for (int cyc = 0; cyc < 60 && n < 8; cyc++) begin
            tick();
            check("fair_no_grant1", 64'(grant[1]), 64'(0));
            if (ack != 3'b000) begin
                check("fair_ack", 64'(ack), (n % 2 == 0) ? 64'(3'b001) : 64'(3'b100));
                n++;
            end
        end
        req = 3'b000;
        check("fair_count", 64'(n), 64'(8));
        tick();

        // Reset mid-read: requester 0 reads first so rdata and last are non-default
        req = 3'b001; we = 3'b000; addr0 = 5'd10;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 4) begin
                check("pre_ack", 64'(ack), 64'(3'b001));
                check("pre_rdata", 64'(rdata), 64'(48'hA0A0A0A0A0A0));
                req = 3'b000;
            end
        end
        tick();
        req = 3'b010; we = 3'b000; addr1 = 5'd5;
        tick(); tick();
        check("mid_wait_busy", 64'(busy), 64'(1));
        req = 3'b000; resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("mid_grant", 64'(grant), 64'(0));
        check("mid_ack", 64'(ack), 64'(0));
        check("mid_rdata", 64'(rdata), 64'(0));
        check("mid_busy", 64'(busy), 64'(0));
        for (int c = 0; c < 5; c++) begin
            tick();
            check("mid_no_ack", 64'(ack), 64'(0));
        end
        req = 3'b011; we = 3'b011; addr0 = 5'd15; addr1 = 5'd16;
        tick();
        check("post_rst_winner", 64'(grant), 64'(3'b001));
        tick();
        check("post_rst_ack0", 64'(ack), 64'(3'b001));
        req = 3'b010;
        tick(); tick(); tick();
        check("post_rst_ack1", 64'(ack), 64'(3'b010));
        req = 3'b000;
        tick();

        // Withdrawn request: requester 2 holds req for one cycle only
        req = 3'b100; we = 3'b100; addr2 = 5'd20; wdata2 = 48'hFEDCBA987654;
        tick();
        req = 3'b000;
        check("wd_mem_we", 64'(mem_we), 64'(1));
        check("wd_grant", 64'(grant), 64'(3'b100));
        check("wd_mem_addr", 64'(mem_addr), 64'(20));
        tick();
        check("wd_ack", 64'(ack), 64'(3'b100));
        tick();
        check("wd_busy", 64'(busy), 64'(0));
        check("wd_grant_idle", 64'(grant), 64'(0));
        check("wd_mem", 64'(mem[20]), 64'(48'hFEDCBA987654));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Round-robin arbiter sharing the single-port 48-bit coin/state memory between three requesters: the transaction datapath, the display reader and the user-input path. It sits between those requesters and the memory port that `memory_control` otherwise drives. It serialises one read or write at a time, holds the address stable for the memory's read latency, returns read data, and pulses a per-requester acknowledge.

## Interface
- `DATA_W`, 48: memory word width.
- `ADDR_W`, 5: memory address width.
- `READ_LAT`, 2: cycles from address presentation to valid `mem_q`. Legal range is 1..15.

- `clock`  in  1  single system clock; all state updates on its rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `req`  in  3  per-requester request level; bit i belongs to requester i.
- `we`  in  3  per-requester access type; 1 = write, 0 = read. Sampled with `req`.
- `addr0`, `addr1`, `addr2`  in  ADDR_W each  per-requester address.
- `wdata0`, `wdata1`, `wdata2`  in  DATA_W each  per-requester write data.
- `grant`  out  3  one-hot owner of the memory port; 0 when idle.
- `ack`  out  3  one-cycle completion pulse to the owner.
- `rdata`  out  DATA_W  registered read data; valid in the `ack` cycle of a read.
- `busy`  out  1  high whenever the state is not IDLE.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_we`  out  1  memory write enable.
- `mem_q`  in  DATA_W  memory read data.

## Operation
- Four states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - `grant`=0 and `mem_we`=0.
  - If any `req` bit is high, select a winner by round robin, starting at (`last`+1) mod 3 and wrapping.
  - Latch the winner's index, `we`, address and wdata into internal registers, then go to ISSUE.
  - If no request is pending, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - `grant[idx]`=1; `mem_addr` and `mem_wdata` come from the latched values.
  - `mem_we` equals the latched `we`.
  - A write goes to DONE. A read loads counter = READ_LAT-1 and goes to WAIT.
- WAIT:
  - `grant[idx]`=1, `mem_addr` held, `mem_we`=0.
  - Counter decrements each cycle. When it is 0, capture `mem_q` into `rdata` and go to DONE.
- DONE (exactly 1 cycle):
  - `grant[idx]`=1 and `ack[idx]`=1; `last` <= `idx`.
  - Go to IDLE.
  - `rdata` is unchanged on writes.
- Latched operands are used for the whole transaction. Changing requester inputs after the IDLE sampling cycle has no effect.
- Withdrawing `req` before `ack` does not abort the transaction: the write still commits and `ack` still pulses.
- Requesters deassert `req` in the cycle they see `ack`. A `req` still high in the following IDLE cycle is treated as a new request.
- `mem_addr` and `mem_wdata` are 0 in IDLE.
- The `ack` and `grant` bits of non-owners are always 0.

## Timing
- Reset, on the first edge with `resetn`=0, from any state:
  - state = IDLE; `grant`, `ack`, `mem_we`, `busy` = 0.
  - `rdata`, `mem_addr`, `mem_wdata` = 0.
  - `last` = 2, so requester 0 has priority first; counter = 0.
- A transaction interrupted by reset is abandoned with no `ack`. A write whose ISSUE cycle already passed has already committed.
- Write: `req` sampled in IDLE in cycle 0, ISSUE in cycle 1 (`mem_we`=1 for exactly this cycle), `ack` in cycle 2.
- Read: ISSUE in cycle 1, WAIT in cycles 2..1+READ_LAT.
  - `mem_q` is sampled at the end of cycle 1+READ_LAT.
  - `ack` and valid `rdata` appear in cycle 2+READ_LAT; for the default that is cycle 4.
- At least one IDLE cycle separates transactions. Minimum spacing is 3 cycles for writes and 3+READ_LAT cycles for reads.
- No starvation: with all three requesting continuously, each requester is served once in every three consecutive grants.
- Requests arriving while not in IDLE are not sampled until the next IDLE cycle.

## Test plan
- Single read, READ_LAT=2: memory model holds word 0x00000000ABCD at address 5; requester 1 raises `req` with `we`=0, addr1=5 in cycle 0. Required: `grant`=3'b010 in cycles 1–4, `mem_addr`=5 in cycles 1–3, `ack`=3'b010 only in cycle 4, `rdata`=0x00000000ABCD.
- Single write: requester 0 writes 0x123456789ABC to address 3. Required: `mem_we`=1 only in cycle 1, with `mem_addr`=3 and `mem_wdata`=0x123456789ABC; `ack`=3'b001 in cycle 2. A following read of address 3 returns 0x123456789ABC.
- Simultaneous requests: all three `req` bits rise in the same cycle after reset, writes only, each held until its own `ack`. Required: grant order 0, 1, 2; `ack` cycles 2, 5 and 8.
- Fairness: requesters 0 and 2 hold `req` continuously for 8 transactions. Required: grants alternate 0,2,0,2,…; requester 1 never granted.
- Reset mid-read: `resetn`=0 in the WAIT cycle of a read. Required: the next cycle shows state IDLE with `grant`=0, `ack`=0, `rdata`=0, and no `ack` ever issued for that read. The next request from requester 0 wins first.
- Withdrawn request: requester 2 raises a write `req` for one cycle only. Required: the write commits in cycle 1 and `ack`=3'b100 in cycle 2; `busy` then returns to 0.
